// File: rtl/digital_lock_system.sv
// ============================================================================
// digital_lock_system : keypad lock matching a 4-nibble code, timed unlock,
//                       and a timed lockout after repeated wrong digits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module digital_lock_system #(
    parameter logic [15:0] CODE           = 16'hA5C3,
    parameter int          MAX_FAIL       = 3,
    parameter int          UNLOCK_CYCLES  = 8,
    parameter int          LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_seq,
    output logic [3:0] unlock,
    output logic [1:0] progress,
    output logic       lockout
);

    // The timer holds "cycles remaining minus one", so it needs clog2(max) bits.
    localparam int c_TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int c_TW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    localparam logic [c_TW-1:0] c_UNLOCK_LOAD  = c_TW'(UNLOCK_CYCLES - 1);
    localparam logic [c_TW-1:0] c_LOCKOUT_LOAD = c_TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]      c_MAX_FAIL     = 4'(MAX_FAIL);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D1   = 3'd1,
        D2   = 3'd2,
        D3   = 3'd3,
        OPEN = 3'd4,
        LOCK = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        fail_q, fail_d;
    logic [c_TW-1:0]   timer_q, timer_d;
    logic [3:0]        unlock_q, unlock_d;
    logic [1:0]        progress_q, progress_d;
    logic              lockout_q, lockout_d;

    logic [3:0]        w_expected;
    logic [3:0]        w_fail_inc;

    assign w_fail_inc = fail_q + 4'd1;

    always_comb begin
        w_expected = CODE[15:12];
        case (state_q)
            D1:      w_expected = CODE[11:8];
            D2:      w_expected = CODE[7:4];
            D3:      w_expected = CODE[3:0];
            default: w_expected = CODE[15:12];
        endcase
    end

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        case (state_q)
            IDLE, D1, D2, D3: begin
                if (in_valid) begin
                    if (in_seq == w_expected) begin
                        case (state_q)
                            IDLE: state_d = D1;
                            D1:   state_d = D2;
                            D2:   state_d = D3;
                            default: begin
                                state_d = OPEN;
                                timer_d = c_UNLOCK_LOAD;
                                fail_d  = 4'd0;
                            end
                        endcase
                    end else begin
                        // The mismatching digit is consumed here, never retried as digit 1.
                        fail_d = w_fail_inc;
                        if (w_fail_inc == c_MAX_FAIL) begin
                            state_d = LOCK;
                            timer_d = c_LOCKOUT_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            OPEN: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            LOCK: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    fail_d  = 4'd0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                fail_d  = 4'd0;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        unlock_d   = 4'h0;
        progress_d = 2'd0;
        lockout_d  = 1'b0;
        case (state_d)
            D1:      progress_d = 2'd1;
            D2:      progress_d = 2'd2;
            D3:      progress_d = 2'd3;
            OPEN:    unlock_d   = 4'hF;
            LOCK:    lockout_d  = 1'b1;
            default: progress_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fail_q     <= 4'd0;
            timer_q    <= '0;
            unlock_q   <= 4'h0;
            progress_q <= 2'd0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            unlock_q   <= unlock_d;
            progress_q <= progress_d;
            lockout_q  <= lockout_d;
        end
    end

    assign unlock   = unlock_q;
    assign progress = progress_q;
    assign lockout  = lockout_q;

endmodule

`default_nettype wire

// File: tb/tb_digital_lock_system.sv
// ============================================================================
// tb_digital_lock_system : scoreboard bench for digital_lock_system.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_digital_lock_system;

    localparam logic [15:0] c_CODE    = 16'hA5C3;
    localparam int          c_MAXF    = 3;
    localparam int          c_UNLOCK  = 8;
    localparam int          c_LOCKOUT = 16;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_seq;
    logic [3:0] unlock;
    logic [1:0] progress;
    logic       lockout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_open   = 0;
    int n_lock   = 0;

    // Reference model: 0..3 = matched digits, 4 = open, 5 = locked out.
    int m_st   = 0;
    int m_fail = 0;
    int m_cnt  = 0;

    logic [6:0] exp_q[$];

    digital_lock_system #(
        .CODE           (c_CODE),
        .MAX_FAIL       (c_MAXF),
        .UNLOCK_CYCLES  (c_UNLOCK),
        .LOCKOUT_CYCLES (c_LOCKOUT)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_seq   (in_seq),
        .unlock   (unlock),
        .progress (progress),
        .lockout  (lockout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_out();
        logic [3:0] u;
        logic [1:0] p;
        logic       l;
        u = (m_st == 4) ? 4'hF : 4'h0;
        p = (m_st < 4) ? 2'(m_st) : 2'd0;
        l = (m_st == 5);
        return {u, p, l};
    endfunction

    task automatic model_step(input logic v, input logic [3:0] d);
        logic [3:0] want;
        if (m_st == 4) begin
            m_cnt--;
            if (m_cnt == 0) m_st = 0;
        end else if (m_st == 5) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_st   = 0;
                m_fail = 0;
            end
        end else if (v) begin
            want = c_CODE[15 - 4*m_st -: 4];
            if (d == want) begin
                if (m_st == 3) begin
                    m_st   = 4;
                    m_cnt  = c_UNLOCK;
                    m_fail = 0;
                end else begin
                    m_st++;
                end
            end else begin
                m_fail++;
                if (m_fail == c_MAXF) begin
                    m_st  = 5;
                    m_cnt = c_LOCKOUT;
                end else begin
                    m_st = 0;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_fail = 0;
        m_cnt  = 0;
    endtask

    task automatic step(input logic v, input logic [3:0] d);
        logic [6:0] e;
        @(negedge clk);
        in_valid = v;
        in_seq   = d;
        model_step(v, d);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("unlock",   32'(unlock),   32'(e[6:3]));
            check("progress", 32'(progress), 32'(e[2:1]));
            check("lockout",  32'(lockout),  32'(e[0]));
        end
        if (unlock == 4'hF) n_open++;
        if (lockout)        n_lock++;
    endtask

    task automatic enter_code();
        step(1'b1, 4'hA);
        step(1'b1, 4'h5);
        step(1'b1, 4'hC);
        step(1'b1, 4'h3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_seq   = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_unlock",   32'(unlock),   32'h0);
        check("reset_progress", 32'(progress), 32'h0);
        check("reset_lockout",  32'(lockout),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Straight correct code, unlock window length.
        n_open = 0;
        enter_code();
        idle(12);
        check("open_cycles_1", 32'(n_open), 32'(c_UNLOCK));

        // One wrong digit then the correct code.
        step(1'b1, 4'hA);
        step(1'b1, 4'h5);
        step(1'b1, 4'h7);
        n_open = 0;
        enter_code();
        idle(12);
        check("open_cycles_2", 32'(n_open), 32'(c_UNLOCK));

        // Three wrong digits lock out; correct code inside lockout is ignored.
        n_open = 0;
        n_lock = 0;
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        enter_code();
        idle(16);
        check("lock_cycles", 32'(n_lock), 32'(c_LOCKOUT));
        check("open_during_lock", 32'(n_open), 32'd0);
        n_open = 0;
        enter_code();
        idle(12);
        check("open_after_lock", 32'(n_open), 32'(c_UNLOCK));

        // Gaps of three idle cycles between digits.
        n_open = 0;
        step(1'b1, 4'hA); idle(3);
        step(1'b1, 4'h5); idle(3);
        step(1'b1, 4'hC); idle(3);
        step(1'b1, 4'h3);
        idle(12);
        check("open_cycles_gaps", 32'(n_open), 32'(c_UNLOCK));

        // Repeated first digit is not re-evaluated as digit 1.
        n_open = 0;
        step(1'b1, 4'hA);
        step(1'b1, 4'hA);
        step(1'b1, 4'h5);
        step(1'b1, 4'hC);
        step(1'b1, 4'h3);
        idle(20);
        check("no_open_after_repeat", 32'(n_open), 32'd0);

        // Asynchronous reset midway through the unlock window.
        enter_code();
        idle(3);
        #2;
        rst = 1'b1;
        #1;
        check("async_unlock",   32'(unlock),   32'h0);
        check("async_progress", 32'(progress), 32'h0);
        check("async_lockout",  32'(lockout),  32'h0);
        model_reset();
        #1;
        rst = 1'b0;
        // Two wrong digits after reset stay below the lockout threshold.
        step(1'b1, 4'h1);
        step(1'b1, 4'h2);
        step(1'b1, 4'hA);
        idle(3);

        if (exp_q.size() != 0) check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/digital_lock_system.md
Name:
digital_lock_system

Overview:
Sequential keypad lock controller. It accepts a stream of 4-bit digit entries and compares them against a parameterised 4-digit code. On a full match it asserts a 4-bit unlock vector for a fixed time. Repeated wrong entries trigger a timed lockout. It sits between a keypad/digit-entry front end and the actuator/status logic.

Parameters:
CODE, 16'hA5C3, secret code as four nibbles; digit 1 is CODE[15:12] and digit 4 is CODE[3:0].
MAX_FAIL, 3, number of wrong digits (1..15) that triggers lockout.
UNLOCK_CYCLES, 8, number of clock cycles unlock stays asserted (>=1).
LOCKOUT_CYCLES, 16, number of clock cycles lockout stays asserted (>=1).

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
in_valid  input  1  qualifies in_seq; one digit is consumed per cycle while high
in_seq  input  4  entered digit
unlock  output  4  4'hF while open, 4'h0 otherwise
progress  output  2  count of correctly matched leading digits (0..3)
lockout  output  1  high while in lockout

Behaviour:
- One clock, asynchronous active-high reset. Reset is fixed as asynchronous and active-high.
- States: IDLE (progress 0), D1, D2, D3 (progress 1..3), OPEN, LOCK.
- Reset state: IDLE. Reset values: unlock=4'h0, progress=0, lockout=0, fail counter=0, timer=0.
- Reset asserted in any state forces these values immediately, without waiting for a clock edge.
- All outputs are registered and decoded from state only.
- in_valid=0: state, fail counter and timer hold, except that OPEN and LOCK timers keep counting.
- IDLE/D1/D2/D3 with in_valid=1:
  - If in_seq equals the expected nibble for the current progress, advance one state.
  - A correct 4th digit (from D3) goes to OPEN on that edge.
  - On a mismatch, return to IDLE and increment the fail counter.
  - The mismatching digit is not re-evaluated as digit 1, even if it equals CODE[15:12].
  - If the incremented fail count equals MAX_FAIL, go to LOCK instead of IDLE.
- OPEN:
  - unlock=4'hF, starting the cycle after the edge that sampled the 4th digit.
  - Lasts exactly UNLOCK_CYCLES cycles, then IDLE.
  - Entering OPEN clears the fail counter.
  - in_valid/in_seq are ignored.
- LOCK:
  - lockout=1 for exactly LOCKOUT_CYCLES cycles, then IDLE with the fail counter cleared.
  - in_valid/in_seq are ignored, including correct codes.
- The fail counter persists across partial correct entries. It clears only on unlock, on lockout expiry, or on reset.
- Timer width: enough bits for max(UNLOCK_CYCLES, LOCKOUT_CYCLES). The timer reloads on entry to OPEN or LOCK.
- unlock and lockout are never high together.
- unlock is only 4'h0 or 4'hF.

Test Plan:
- Reset, then in_valid=1 for four cycles with in_seq=A,5,C,3 -> progress 1,2,3 after each edge. unlock=4'hF for exactly 8 cycles, then 4'h0, progress=0.
- Enter A,5 then 7 -> progress returns to 0 (fail=1). Then A,5,C,3 -> unlock=4'hF for 8 cycles.
- Enter wrong digits 0,0,0 -> lockout=1 for 16 cycles. A,5,C,3 entered during lockout -> unlock stays 4'h0. After expiry, A,5,C,3 -> unlock=4'hF.
- Enter A,5,C,3 with in_valid=0 gaps of 3 cycles between digits -> progress holds during gaps. Unlock occurs after the 4th valid digit.
- Enter A then A (mismatch at digit 2) then 5,C,3 -> no unlock, progress=0 after the mismatch. The second A is not counted as digit 1.
- Assert rst for part of a cycle midway through OPEN -> unlock drops to 4'h0 immediately without a clock edge, state IDLE, fail=0.
